pc_redirect_ctrl: RTL and testbench

//  Sequences all non-sequential updates of the PC register. It drives the PC block's write port (pc_en/pc_reg).

---
 rtl/pc_redirect_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: sequences every non-sequential PC update.
// Branch writes go straight to the PC write port in the same cycle. Exceptions are
// arbitrated, the front end is flushed for DRAIN_CYCLES, and then the vector address is loaded.
// Optional feature macro: VECTOR_HIGH_EN (adds i_vec_high to select the high vector table).
module pc_redirect_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter logic [31:0] VECTOR_BASE  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] i_pc,
   input  logic        i_br_valid,
   input  logic [31:0] i_br_target,
   input  logic [5:0]  i_exc_req,
   input  logic        i_irq_mask,
   input  logic        i_fiq_mask,
`ifdef VECTOR_HIGH_EN
   input  logic        i_vec_high,
`endif
   output logic        o_pc_en,
   output logic [31:0] o_pc_reg,
   output logic        o_flush,
   output logic        o_busy,
   output logic        o_exc_ack,
   output logic [2:0]  o_exc_cause,
   output logic [31:0] o_ret_addr
);

   typedef enum logic [1:0] {StRun, StDrain, StRedirect} state_e;

   // Bit positions inside i_exc_req
   localparam int unsigned BitUndef = 0;
   localparam int unsigned BitSwi   = 1;
   localparam int unsigned BitPabt  = 2;
   localparam int unsigned BitDabt  = 3;
   localparam int unsigned BitIrq   = 4;
   localparam int unsigned BitFiq   = 5;

   localparam logic [1:0] CntLoad = 2'(DRAIN_CYCLES - 1);

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [2:0]  cause_q, cause_d;
   logic [31:0] ret_addr_q, ret_addr_d;
   logic [31:0] base;

   logic [5:0]  pend;
   logic [2:0]  win_cause;
   logic [31:0] vec_offset;

`ifdef VECTOR_HIGH_EN
   logic [31:0] base_q, base_d;
   assign base = base_q;
`else
   assign base = VECTOR_BASE;
`endif

   // Mask irq/fiq with the CPSR bits and pick the winner: dabt > fiq > irq > pabt > undef > swi
   always_comb begin
      pend = i_exc_req;
      if (i_irq_mask) pend[BitIrq] = 1'b0;
      if (i_fiq_mask) pend[BitFiq] = 1'b0;
      win_cause = 3'd0;
      if (pend[BitDabt])       win_cause = 3'd4;
      else if (pend[BitFiq])   win_cause = 3'd6;
      else if (pend[BitIrq])   win_cause = 3'd5;
      else if (pend[BitPabt])  win_cause = 3'd3;
      else if (pend[BitUndef]) win_cause = 3'd1;
      else if (pend[BitSwi])   win_cause = 3'd2;
   end

   // Vector table offset for the latched cause
   always_comb begin
      vec_offset = 32'h0;
      case (cause_q)
         3'd1:    vec_offset = 32'h04;
         3'd2:    vec_offset = 32'h08;
         3'd3:    vec_offset = 32'h0C;
         3'd4:    vec_offset = 32'h10;
         3'd5:    vec_offset = 32'h18;
         3'd6:    vec_offset = 32'h1C;
         default: vec_offset = 32'h0;
      endcase
   end

   // Next-state and output decode; en=0 holds all state and suppresses the write/ack strobes
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cause_d    = cause_q;
      ret_addr_d = ret_addr_q;
`ifdef VECTOR_HIGH_EN
      base_d     = base_q;
`endif
      o_pc_en    = 1'b0;
      o_pc_reg   = 32'h0;
      o_flush    = 1'b0;
      o_busy     = 1'b0;
      o_exc_ack  = 1'b0;

      unique case (state_q)
         StRun: begin
            if (en) begin
               if (|pend) begin
                  // Accept: any coincident branch is dropped
                  cause_d    = win_cause;
                  ret_addr_d = i_pc;
                  cnt_d      = CntLoad;
                  o_flush    = 1'b1;
                  state_d    = StDrain;
`ifdef VECTOR_HIGH_EN
                  base_d     = i_vec_high ? 32'hFFFF_0000 : VECTOR_BASE;
`endif
               end else if (i_br_valid) begin
                  o_pc_en  = 1'b1;
                  o_pc_reg = i_br_target;
               end
            end
         end
         StDrain: begin
            o_flush = 1'b1;
            o_busy  = 1'b1;
            if (en) begin
               if (cnt_q == 2'd0) state_d = StRedirect;
               else               cnt_d   = cnt_q - 2'd1;
            end
         end
         StRedirect: begin
            o_busy   = 1'b1;
            o_pc_reg = base + vec_offset;
            if (en) begin
               o_pc_en   = 1'b1;
               o_exc_ack = 1'b1;
               state_d   = StRun;
            end
         end
         default: state_d = StRun;
      endcase

      // Reset quiets every output in the cycle it is applied
      if (rst) begin
         o_pc_en   = 1'b0;
         o_pc_reg  = 32'h0;
         o_flush   = 1'b0;
         o_busy    = 1'b0;
         o_exc_ack = 1'b0;
      end
   end

   // State registers with synchronous reset; a reset mid-sequence aborts without an ack
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StRun;
         cnt_q      <= 2'd0;
         cause_q    <= 3'd0;
         ret_addr_q <= 32'h0;
`ifdef VECTOR_HIGH_EN
         base_q     <= VECTOR_BASE;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cause_q    <= cause_d;
         ret_addr_q <= ret_addr_d;
`ifdef VECTOR_HIGH_EN
         base_q     <= base_d;
`endif
      end
   end

   assign o_exc_cause = cause_q;
   assign o_ret_addr  = ret_addr_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl (DRAIN_CYCLES=2, VECTOR_BASE=0).
module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic [31:0] pc_drv = 32'h0;
   logic        br_valid = 1'b0;
   logic [31:0] br_target = 32'h0;
   logic [5:0]  exc_req = 6'b0;
   logic        irq_mask = 1'b0;
   logic        fiq_mask = 1'b0;
`ifdef VECTOR_HIGH_EN
   logic        vec_high = 1'b0;
`endif
   logic        o_pc_en, o_flush, o_busy, o_exc_ack;
   logic [31:0] o_pc_reg, o_ret_addr;
   logic [2:0]  o_exc_cause;
   logic [31:0] pc_model = 32'h0;
   logic [3:0]  st;

   int total = 0;
   int bad   = 0;

   pc_redirect_ctrl #(.DRAIN_CYCLES(2), .VECTOR_BASE(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .en(en), .i_pc(pc_drv),
      .i_br_valid(br_valid), .i_br_target(br_target), .i_exc_req(exc_req),
      .i_irq_mask(irq_mask), .i_fiq_mask(fiq_mask),
`ifdef VECTOR_HIGH_EN
      .i_vec_high(vec_high),
`endif
      .o_pc_en(o_pc_en), .o_pc_reg(o_pc_reg), .o_flush(o_flush), .o_busy(o_busy),
      .o_exc_ack(o_exc_ack), .o_exc_cause(o_exc_cause), .o_ret_addr(o_ret_addr)
   );

   always #5 clk = ~clk;

   // Simple PC block: takes the written value on the strobe
   always @(posedge clk) if (o_pc_en) pc_model <= o_pc_reg;

   // Status packed as {flush, busy, pc_en, ack}
   assign st = {o_flush, o_busy, o_pc_en, o_exc_ack};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(); tick();
      #2;
      total++; if (st !== 4'b0000) begin bad++; $display("FAIL rst_status got=%b want=0000", st); end
      total++; if (o_pc_reg !== 32'h0) begin bad++; $display("FAIL rst_pc_reg got=%h want=0", o_pc_reg); end
      total++; if (o_exc_cause !== 3'd0) begin bad++; $display("FAIL rst_cause got=%0d want=0", o_exc_cause); end
      total++; if (o_ret_addr !== 32'h0) begin bad++; $display("FAIL rst_ret got=%h want=0", o_ret_addr); end
      rst = 1'b0;
      #1;
      total++; if (st !== 4'b0000) begin bad++; $display("FAIL rst_release got=%b want=0000", st); end
      tick();
   endtask

   task automatic test_branch;
      br_valid = 1'b1; br_target = 32'h0000_0100;
      #2;
      total++; if (o_pc_en !== 1'b1) begin bad++; $display("FAIL br_pc_en got=%b want=1", o_pc_en); end
      total++; if (o_pc_reg !== 32'h100) begin bad++; $display("FAIL br_pc_reg got=%h want=100", o_pc_reg); end
      tick();
      br_valid = 1'b0;
      #2;
      total++; if (pc_model !== 32'h100) begin bad++; $display("FAIL br_pc_loaded got=%h want=100", pc_model); end
      total++; if (o_pc_reg !== 32'h0) begin bad++; $display("FAIL br_idle_pc_reg got=%h want=0", o_pc_reg); end
   endtask

   task automatic test_irq_swi;
      pc_drv = 32'h40; exc_req = 6'b010010; br_valid = 1'b1; br_target = 32'h300;
      #2;
      total++; if (st !== 4'b1000) begin bad++; $display("FAIL acc_status got=%b want=1000", st); end
      tick();
      for (int i = 0; i < 2; i++) begin
         #2;
         total++; if (st !== 4'b1100) begin bad++; $display("FAIL drain%0d got=%b want=1100", i, st); end
         tick();
      end
      br_valid = 1'b0;
      #2;
      total++; if (st !== 4'b0111) begin bad++; $display("FAIL irq_redir got=%b want=0111", st); end
      total++; if (o_pc_reg !== 32'h18) begin bad++; $display("FAIL irq_vec got=%h want=18", o_pc_reg); end
      total++; if (o_exc_cause !== 3'd5) begin bad++; $display("FAIL irq_cause got=%0d want=5", o_exc_cause); end
      total++; if (o_ret_addr !== 32'h40) begin bad++; $display("FAIL irq_ret got=%h want=40", o_ret_addr); end
      tick();
      // irq dropped after its ack; swi still held and wins the next RUN cycle
      exc_req = 6'b000010; pc_drv = 32'h44;
      #2;
      total++; if (st !== 4'b1000) begin bad++; $display("FAIL swi_acc got=%b want=1000", st); end
      tick(); tick(); tick();
      #2;
      total++; if (o_exc_ack !== 1'b1) begin bad++; $display("FAIL swi_ack got=%b want=1", o_exc_ack); end
      total++; if (o_pc_reg !== 32'h08) begin bad++; $display("FAIL swi_vec got=%h want=08", o_pc_reg); end
      total++; if (o_exc_cause !== 3'd2) begin bad++; $display("FAIL swi_cause got=%0d want=2", o_exc_cause); end
      total++; if (o_ret_addr !== 32'h44) begin bad++; $display("FAIL swi_ret got=%h want=44", o_ret_addr); end
      exc_req = 6'b0;
      tick();
      #2;
      total++; if (st !== 4'b0000) begin bad++; $display("FAIL swi_idle got=%b want=0000", st); end
   endtask

   task automatic test_priority;
      logic [5:0]  reqs  [3];
      logic [31:0] vecs  [3];
      logic [2:0]  cause [3];
      reqs[0] = 6'b111000; vecs[0] = 32'h10; cause[0] = 3'd4;
      reqs[1] = 6'b110000; vecs[1] = 32'h1C; cause[1] = 3'd6;
      reqs[2] = 6'b010000; vecs[2] = 32'h18; cause[2] = 3'd5;
      pc_drv = 32'h80;
      for (int i = 0; i < 3; i++) begin
         exc_req = reqs[i];
         tick(); tick(); tick();
         #2;
         total++; if (o_exc_ack !== 1'b1) begin bad++; $display("FAIL prio%0d_ack got=%b want=1", i, o_exc_ack); end
         total++; if (o_pc_reg !== vecs[i]) begin bad++; $display("FAIL prio%0d_vec got=%h want=%h", i, o_pc_reg, vecs[i]); end
         total++; if (o_exc_cause !== cause[i]) begin bad++; $display("FAIL prio%0d_cause got=%0d want=%0d", i, o_exc_cause, cause[i]); end
         tick();
      end
      exc_req = 6'b0;
   endtask

   task automatic test_mask;
      irq_mask = 1'b1; exc_req = 6'b010000;
      #2;
      total++; if (st !== 4'b0000) begin bad++; $display("FAIL irq_masked got=%b want=0000", st); end
      tick(); tick();
      #2;
      total++; if (st !== 4'b0000) begin bad++; $display("FAIL irq_masked_held got=%b want=0000", st); end
      irq_mask = 1'b0;
      #1;
      total++; if (st !== 4'b1000) begin bad++; $display("FAIL irq_unmask_acc got=%b want=1000", st); end
      tick();
      #2;
      total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL irq_unmask_busy got=%b want=1", o_busy); end
      tick(); tick();
      #2;
      total++; if (o_exc_cause !== 3'd5) begin bad++; $display("FAIL irq_unmask_cause got=%0d want=5", o_exc_cause); end
      exc_req = 6'b100000; fiq_mask = 1'b1;
      tick();
      #2;
      total++; if (st !== 4'b0000) begin bad++; $display("FAIL fiq_masked got=%b want=0000", st); end
      exc_req = 6'b0; fiq_mask = 1'b0;
      tick();
   endtask

   task automatic test_en_freeze;
      pc_drv = 32'h200; exc_req = 6'b000001;
      tick();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         total++; if (st !== 4'b1100) begin bad++; $display("FAIL frz%0d got=%b want=1100", i, st); end
         tick();
      end
      en = 1'b1;
      tick();
      #2;
      total++; if (st !== 4'b1100) begin bad++; $display("FAIL frz_late_drain got=%b want=1100", st); end
      tick();
      en = 1'b0;
      #2;
      total++; if (st !== 4'b0100) begin bad++; $display("FAIL frz_redir_hold got=%b want=0100", st); end
      tick();
      en = 1'b1;
      #2;
      total++; if (st !== 4'b0111) begin bad++; $display("FAIL frz_redir got=%b want=0111", st); end
      total++; if (o_pc_reg !== 32'h04) begin bad++; $display("FAIL frz_vec got=%h want=04", o_pc_reg); end
      total++; if (o_ret_addr !== 32'h200) begin bad++; $display("FAIL frz_ret got=%h want=200", o_ret_addr); end
      exc_req = 6'b0;
      tick();
   endtask

   task automatic test_reset_mid;
      pc_drv = 32'h500; exc_req = 6'b001000;
      tick();
      #2;
      total++; if (st !== 4'b1100) begin bad++; $display("FAIL rmid_drain got=%b want=1100", st); end
      rst = 1'b1; exc_req = 6'b0;
      tick();
      #2;
      total++; if (st !== 4'b0000) begin bad++; $display("FAIL rmid_status got=%b want=0000", st); end
      total++; if (o_exc_cause !== 3'd0) begin bad++; $display("FAIL rmid_cause got=%0d want=0", o_exc_cause); end
      total++; if (o_ret_addr !== 32'h0) begin bad++; $display("FAIL rmid_ret got=%h want=0", o_ret_addr); end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         #2;
         total++; if (st !== 4'b0000) begin bad++; $display("FAIL rmid_post%0d got=%b want=0000", i, st); end
      end
   endtask

`ifdef VECTOR_HIGH_EN
   task automatic test_vec_high;
      vec_high = 1'b1; exc_req = 6'b000001;
      tick();
      vec_high = 1'b0;
      tick(); tick();
      #2;
      total++; if (o_pc_reg !== 32'hFFFF_0004) begin bad++; $display("FAIL vhigh_vec got=%h want=ffff0004", o_pc_reg); end
      exc_req = 6'b0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_branch();
      test_irq_swi();
      test_priority();
      test_mask();
      test_en_freeze();
      test_reset_mid();
`ifdef VECTOR_HIGH_EN
      test_vec_high();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
